// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS multi-cycle control unit:
// state encoding, opcode/funct values, ALU codes and the packed control word.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // alu_en marks states that actually use the ALU; elsewhere ALUControl reads 0.
   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       pc_src;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       pc_write;
      logic       branch;
      logic       alu_en;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/mips_multi_cycle_control_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp/Funct to ALUControl and flags
// whether Funct is one of the supported R-type operations.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [1:0] i_alu_op,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_control,
   output logic       o_funct_valid
);

   logic [2:0] w_funct_ctl;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      w_funct_ctl   = ALU_ADD;
      o_funct_valid = 1'b1;
      case (i_funct)
         FN_ADD:  w_funct_ctl = ALU_ADD;
         FN_SUB:  w_funct_ctl = ALU_SUB;
         FN_AND:  w_funct_ctl = ALU_AND;
         FN_OR:   w_funct_ctl = ALU_OR;
         FN_SLT:  w_funct_ctl = ALU_SLT;
         default: o_funct_valid = 1'b0;
      endcase

      case (i_alu_op)
         ALUOP_ADD: o_alu_control = ALU_ADD;
         ALUOP_SUB: o_alu_control = ALU_SUB;
         default:   o_alu_control = w_funct_ctl;
      endcase
   end

endmodule

// File: rtl/mips_multi_cycle_control.sv
// Moore control FSM for the MIPS multi-cycle datapath.
// Define MIPS_CTRL_ADDI_EN to build the addi path (ADDIEXEC/ADDIWB).
module mips_multi_cycle_control
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       zero,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       PCEn,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       PCWrite,
   output logic       Branch,
   output logic [2:0] ALUControl,
   output logic       Instr_Done,
   output logic       Illegal
);

   state_t     r_state;
   state_t     w_next_state;
   ctrl_t      w_ctrl;
   ctrl_t      w_out;
   logic [2:0] w_alu_control;
   logic       w_funct_valid;

   alu_decoder u_alu_decoder (
      .i_alu_op      (w_ctrl.alu_op),
      .i_funct       (Funct),
      .o_alu_control (w_alu_control),
      .o_funct_valid (w_funct_valid)
   );

   // NOTE: sequential state uses non-blocking assignment so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = S_FETCH;
      w_ctrl       = '0;
      case (r_state)
         S_FETCH: begin
            w_ctrl.alu_src_b = 2'b01;
            w_ctrl.alu_en    = 1'b1;
            w_ctrl.ir_write  = 1'b1;
            w_ctrl.pc_write  = 1'b1;
            w_next_state     = S_DECODE;
         end
         S_DECODE: begin
            w_ctrl.alu_src_b = 2'b11;
            w_ctrl.alu_en    = 1'b1;
            case (Op)
               OP_LW, OP_SW: w_next_state = S_MEMADR;
               OP_RTYPE: begin
                  if (w_funct_valid) w_next_state   = S_EXECUTE;
                  else               w_ctrl.illegal = 1'b1;
               end
               OP_BEQ:       w_next_state = S_BRANCH;
`ifdef MIPS_CTRL_ADDI_EN
               OP_ADDI:      w_next_state = S_ADDIEXEC;
`endif
               default:      w_ctrl.illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = 2'b10;
            w_ctrl.alu_en    = 1'b1;
            if (Op == OP_LW)      w_next_state = S_MEMREAD;
            else if (Op == OP_SW) w_next_state = S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_ctrl.iord  = 1'b1;
            w_next_state = S_MEMWB;
         end
         S_MEMWB: begin
            w_ctrl.mem_to_reg = 1'b1;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            w_ctrl.iord       = 1'b1;
            w_ctrl.mem_write  = 1'b1;
            w_ctrl.instr_done = 1'b1;
         end
         S_EXECUTE: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_en    = 1'b1;
            w_ctrl.alu_op    = ALUOP_FUNCT;
            w_next_state     = S_ALUWB;
         end
         S_ALUWB: begin
            w_ctrl.reg_dst    = 1'b1;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            w_ctrl.alu_src_a  = 1'b1;
            w_ctrl.alu_en     = 1'b1;
            w_ctrl.alu_op     = ALUOP_SUB;
            w_ctrl.pc_src     = 1'b1;
            w_ctrl.branch     = 1'b1;
            w_ctrl.instr_done = 1'b1;
         end
`ifdef MIPS_CTRL_ADDI_EN
         S_ADDIEXEC: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = 2'b10;
            w_ctrl.alu_en    = 1'b1;
            w_next_state     = S_ADDIWB;
         end
         S_ADDIWB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.instr_done = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Reset blanks every control so a mid-instruction reset cannot write anything.
   assign w_out      = reset ? '0 : w_ctrl;

   assign IorD       = w_out.iord;
   assign MemWrite   = w_out.mem_write;
   assign IRWrite    = w_out.ir_write;
   assign PCSrc      = w_out.pc_src;
   assign RegWrite   = w_out.reg_write;
   assign RegDst     = w_out.reg_dst;
   assign MemtoReg   = w_out.mem_to_reg;
   assign ALUSrcA    = w_out.alu_src_a;
   assign ALUSrcB    = w_out.alu_src_b;
   assign PCWrite    = w_out.pc_write;
   assign Branch     = w_out.branch;
   assign Instr_Done = w_out.instr_done;
   assign Illegal    = w_out.illegal;
   assign ALUControl = w_out.alu_en ? w_alu_control : 3'b000;
   assign PCEn       = w_out.pc_write | (w_out.branch & zero);

endmodule

// File: tb/tb_mips_multi_cycle_control.sv
// Randomized self-checking bench for mips_multi_cycle_control against a
// per-instruction, per-cycle behavioural model of the control outputs.
module tb_mips_multi_cycle_control;

   logic       clk;
   logic       reset;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       zero;
   logic       IorD, MemWrite, IRWrite, PCSrc, RegWrite, PCEn, RegDst, MemtoReg;
   logic       ALUSrcA, PCWrite, Branch, Instr_Done, Illegal;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;

   int n_checks = 0;
   int n_fail   = 0;

   typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_ILL} kind_t;

   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       pcsrc;
      logic       regwrite;
      logic       pcen;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       pcwrite;
      logic       branch;
      logic [2:0] aluctl;
      logic       done;
      logic       illegal;
   } outs_t;

   mips_multi_cycle_control dut (
      .clk        (clk),
      .reset      (reset),
      .Op         (Op),
      .Funct      (Funct),
      .zero       (zero),
      .IorD       (IorD),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .PCSrc      (PCSrc),
      .RegWrite   (RegWrite),
      .PCEn       (PCEn),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .PCWrite    (PCWrite),
      .Branch     (Branch),
      .ALUControl (ALUControl),
      .Instr_Done (Instr_Done),
      .Illegal    (Illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%b exp=%b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic outs_t observe();
      outs_t o;
      o = '{IorD, MemWrite, IRWrite, PCSrc, RegWrite, PCEn, RegDst, MemtoReg,
            ALUSrcA, ALUSrcB, PCWrite, Branch, ALUControl, Instr_Done, Illegal};
      return o;
   endfunction

   // {valid, ALU code} for an R-type funct field
   function automatic logic [3:0] funct_ctl(input logic [5:0] f);
      case (f)
         6'b100000: return 4'b1_010;
         6'b100010: return 4'b1_110;
         6'b100100: return 4'b1_000;
         6'b100101: return 4'b1_001;
         6'b101010: return 4'b1_111;
         default:   return 4'b0_000;
      endcase
   endfunction

   function automatic kind_t kind_of(input logic [5:0] op, input logic [5:0] f);
      logic [3:0] fc;
      fc = funct_ctl(f);
      if (op == 6'b100011) return K_LW;
      if (op == 6'b101011) return K_SW;
      if (op == 6'b000100) return K_BEQ;
      if (op == 6'b000000) return fc[3] ? K_R : K_ILL;
`ifdef MIPS_CTRL_ADDI_EN
      if (op == 6'b001000) return K_ADDI;
`endif
      return K_ILL;
   endfunction

   function automatic int cycles_of(input kind_t k);
      case (k)
         K_LW:    return 5;
         K_BEQ:   return 3;
         K_ILL:   return 2;
         default: return 4;
      endcase
   endfunction

   // Expected outputs in cycle cyc (1 = FETCH) of an instruction of kind k.
   function automatic outs_t model(input kind_t k, input logic [5:0] f, input int cyc,
                                   input logic z);
      outs_t      o;
      logic [3:0] fc;
      o  = '0;
      fc = funct_ctl(f);
      if (cyc == 1) begin
         o.alusrcb = 2'b01; o.aluctl = 3'b010;
         o.irwrite = 1'b1;  o.pcwrite = 1'b1; o.pcen = 1'b1;
      end else if (cyc == 2) begin
         o.alusrcb = 2'b11; o.aluctl = 3'b010;
         o.illegal = (k == K_ILL);
      end else if (cyc == 3) begin
         o.alusrca = 1'b1;
         case (k)
            K_R:   begin o.alusrcb = 2'b00; o.aluctl = fc[2:0]; end
            K_BEQ: begin
               o.alusrcb = 2'b00; o.aluctl = 3'b110; o.pcsrc = 1'b1;
               o.branch  = 1'b1;  o.done = 1'b1;     o.pcen = z;
            end
            default: begin o.alusrcb = 2'b10; o.aluctl = 3'b010; end
         endcase
      end else if (cyc == 4) begin
         case (k)
            K_LW:    o.iord = 1'b1;
            K_SW:    begin o.iord = 1'b1; o.memwrite = 1'b1; o.done = 1'b1; end
            K_R:     begin o.regdst = 1'b1; o.regwrite = 1'b1; o.done = 1'b1; end
            default: begin o.regwrite = 1'b1; o.done = 1'b1; end
         endcase
      end else begin
         o.memtoreg = 1'b1; o.regwrite = 1'b1; o.done = 1'b1;
      end
      return o;
   endfunction

   // zmode: -1 random zero every cycle, 0/1 force zero in the branch cycle.
   // stop_at > 0 asserts reset in that cycle and abandons the instruction.
   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] f,
                            input int zmode, input int stop_at);
      kind_t k;
      int    n;
      k = kind_of(op, f);
      n = cycles_of(k);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         Op    = op;
         Funct = f;
         zero  = (zmode >= 0 && c == 3) ? zmode[0] : 1'($urandom_range(0, 1));
         reset = (c == stop_at);
         #1;
         if (c == stop_at) begin
            check($sformatf("%s reset c%0d", name, c), observe(), '0);
            return;
         end
         check($sformatf("%s c%0d", name, c), observe(), model(k, f, c, zero));
      end
   endtask

   initial begin
      logic [5:0] ops[6];
      logic [5:0] fns[5];
      logic [5:0] op, f;
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000000};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

      reset = 1'b1;
      Op    = 6'b000000;
      Funct = 6'b000000;
      zero  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check($sformatf("reset hold %0d", i), observe(), '0);
      end

      run_instr("lw",       6'b100011, 6'b000000, -1, 0);
      run_instr("sub",      6'b000000, 6'b100010, -1, 0);
      run_instr("beq z1",   6'b000100, 6'b010101,  1, 0);
      run_instr("beq z0",   6'b000100, 6'b000000,  0, 0);
      run_instr("op3f",     6'b111111, 6'b100000, -1, 0);
      run_instr("rbadfn",   6'b000000, 6'b000000, -1, 0);
      run_instr("addi",     6'b001000, 6'b000111, -1, 0);
      run_instr("sw",       6'b101011, 6'b000000, -1, 0);
      run_instr("sw rst",   6'b101011, 6'b000000, -1, 4);
      run_instr("after rst", 6'b000000, 6'b101010, -1, 0);
      run_instr("lw rst",   6'b100011, 6'b000000, -1, 5);
      run_instr("slt",      6'b000000, 6'b101010, -1, 0);

      for (int i = 0; i < 150; i++) begin
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
         f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
         run_instr($sformatf("rnd%0d", i), op, f, -1,
                   ($urandom_range(0, 19) == 0) ? 2 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
